// File: rtl/inst_queue_if.sv
// Handshake/data bundle between IF (master) and the fetch-to-decode instruction queue (slave).
interface inst_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int GHR_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              push_en;
    logic [ADDR_W-1:0] pc_in;
    logic [INST_W-1:0] inst_in;
    logic              is_branch_taken_in;
    logic [GHR_W-1:0]  pht_index_in;
    logic              full;
    logic              pop_en;
    logic              valid;
    logic [ADDR_W-1:0] pc_out;
    logic [INST_W-1:0] inst_out;
    logic              is_branch_taken_out;
    logic [GHR_W-1:0]  pht_index_out;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, push_en, pc_in, inst_in, is_branch_taken_in, pht_index_in, pop_en,
        input  full, valid, pc_out, inst_out, is_branch_taken_out, pht_index_out, count
    );

    modport slave (
        input  flush, push_en, pc_in, inst_in, is_branch_taken_in, pht_index_in, pop_en,
        output full, valid, pc_out, inst_out, is_branch_taken_out, pht_index_out, count
    );
endinterface

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer with wrap-bit pointers and one-cycle flush.
// Define INST_QUEUE_BYPASS_EN to forward a push straight to the outputs when the queue is empty.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int GHR_W  = 8
) (
    input logic         clk,
    input logic         rst,
    inst_queue_if.slave q
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              taken;
        logic [GHR_W-1:0]  pht;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;

    logic   empty;
    logic   full;
    logic   bypass;
    logic   bypass_take;
    logic   pop_acc;
    logic   push_acc;
    logic   wr_en;
    logic   valid_int;
    entry_t in_entry;
    entry_t head_entry;
    entry_t out_entry;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                   (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);

    assign in_entry.pc    = q.pc_in;
    assign in_entry.inst  = q.inst_in;
    assign in_entry.taken = q.is_branch_taken_in;
    assign in_entry.pht   = q.pht_index_in;

    assign head_entry = mem_q[rd_ptr_q[IDX_W-1:0]];

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty && q.push_en && !q.flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that ID takes in the same cycle never touches storage.
    assign bypass_take = bypass && q.pop_en;
    assign pop_acc     = q.pop_en && !empty;
    assign push_acc    = q.push_en && (!full || pop_acc) && !bypass_take;
    assign wr_en       = push_acc && !q.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + PTR_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset: nothing is visible until a pointer moves past it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= in_entry;
        end
    end

    // An empty queue presents all-zero data so ID decodes it as a NOP.
    always_comb begin
        valid_int = !empty;
        out_entry = head_entry;
        if (bypass) begin
            valid_int = 1'b1;
            out_entry = in_entry;
        end
        if (!valid_int) begin
            out_entry = '0;
        end
    end

    assign q.valid               = valid_int;
    assign q.full                = full;
    assign q.count               = count_q;
    assign q.pc_out              = out_entry.pc;
    assign q.inst_out            = out_entry.inst;
    assign q.is_branch_taken_out = out_entry.taken;
    assign q.pht_index_out       = out_entry.pht;

endmodule

// File: doc/inst_queue.md
# inst_queue

Fetch-to-decode instruction queue. It buffers fetched instructions, together with their branch-prediction bits, between the IF stage and the ID stage. IF writes one entry per cycle and ID drains one entry per cycle, so a decode stall does not force an immediate fetch stall. On a pipeline flush the queue empties in a single cycle.

## Interface

Reset is asynchronous, active-low. One clock.

Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `flush`  in  1  discards all entries and any concurrent push.
- `push_en`  in  1  IF presents a valid entry.
- `pc_in`  in  `ADDR_BUS` (32)  fetch PC.
- `inst_in`  in  `INST_BUS` (32)  fetched instruction word.
- `is_branch_taken_in`  in  1  predictor taken bit.
- `pht_index_in`  in  `GHR_BUS`  PHT index used for the prediction.
- `full`  out  1  no free entry.
- `pop_en`  in  1  ID accepts the head entry this cycle (ID is not stalled).
- `valid`  out  1  head entry present.
- `pc_out`  out  `ADDR_BUS`  head PC.
- `inst_out`  out  `INST_BUS`  head instruction.
- `is_branch_taken_out`  out  1  head taken bit.
- `pht_index_out`  out  `GHR_BUS`  head PHT index.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation

- Storage is a circular buffer with read and write pointers. Each pointer is $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty and full are decoded from the pointers:
  - empty: pointers equal.
  - full: index bits equal and wrap bits differ.
- Pop is accepted when `pop_en && valid`. An accepted pop advances the read pointer.
- Push is accepted when `push_en && (!full || pop accepted)`. Push into a full queue together with a pop is legal. An accepted push writes at the write pointer and advances it.
- A push while full with no pop is dropped. IF must hold `push_en` and its data until `full` deasserts.
- `pop_en` with `valid`=0 is ignored.
- `flush` has priority over push and pop. The next state is: both pointers 0, `count`=0. Entry contents are don't-care.
- `count` is the registered occupancy:
  - +1 for an accepted push alone.
  - −1 for an accepted pop alone.
  - unchanged for both together.
  - 0 on flush.
- Pointer wrap-around is natural modulo-2·DEPTH arithmetic. No special casing.
- When `valid`=0, all data outputs read 0. This means an empty queue decodes as a NOP in ID.
- Reset values: pointers 0, `count` 0, `full` 0, `valid` 0, `pc_out`/`inst_out`/`is_branch_taken_out`/`pht_index_out` all 0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Entries in flight are lost.

## Timing

- Without bypass, push-to-visible latency is 1 cycle. An entry pushed at edge N is presented with `valid`=1 after edge N.
- Output data is the combinational read of the head entry. ID samples it into its own pipeline register on the edge where `pop_en`=1.
- `full`, `valid` and `count` are combinational from the registered pointers. They never depend on same-cycle `push_en` or `pop_en`, except for the bypass path described under Configuration.
- A flush in cycle N gives `valid`=0 and `count`=0 in cycle N+1. A push presented in cycle N+1 is accepted normally.

## Configuration

- `INST_QUEUE_BYPASS_EN` defined: when the queue is empty and `push_en`=1, `valid` and the data outputs are driven combinationally from the `*_in` ports in the same cycle.
  - If `pop_en`=1 in that cycle, the entry is consumed. Storage is not written, and pointers and `count` are unchanged.
  - If `pop_en`=0, the entry is written normally.
  - `flush` suppresses the bypass: `valid`=0.
- `INST_QUEUE_BYPASS_EN` undefined: there is no input-to-output combinational path, and latency is always 1 cycle as in Timing.

## Test plan

- **Reset:** hold `rst`=0 for 2 cycles, then release.
  - `valid`=0, `full`=0, `count`=0 and all data outputs 0 throughout.
- **Push then drain, `DEPTH`=4:** push PCs 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c with `pop_en`=0.
  - `full`=1 and `count`=4.
  - A fifth push is dropped.
  - Then set `pop_en`=1: outputs are delivered in order. `inst_out` matches the pushed words, e.g. 0x90001234 then 0xac001234.
- **Full with simultaneous push and pop:** on a full queue, push 0xbfc00010 while popping.
  - `count` stays 4 and the head advances to 0xbfc00004.
  - After 3 more pops, the head is 0xbfc00010, checking wrap-around.
- **Flush:** with 3 entries held, assert `flush` together with a push of 0xbfc00020.
  - Next cycle: `valid`=0 and `count`=0, and 0xbfc00020 never appears at the output.
- **Branch bits:** push `is_branch_taken_in`=1 with `pht_index_in`=5.
  - The popped entry shows the same values.
  - Empty-queue outputs are 0.
- **Bypass, only with `INST_QUEUE_BYPASS_EN`:** on an empty queue, push 0x2408cdef with `pop_en`=1.
  - Same cycle: `valid`=1 and `inst_out`=0x2408cdef.
  - Next cycle: `count`=0.
